// File: rtl/pe_weight_spad_loader.sv
// Weight scratchpad loader for one PE.
// Takes the CSC-compressed weight address and data streams from the weight
// router and writes them into the weight address SPad and weight data SPad.
// There is no backpressure: beats that cannot be stored are dropped and
// flagged. Completion of a filter load is reported as a one-cycle pulse.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for load_start; any incoming beat is dropped
//   LOAD  | storing beats until both latched lengths have been reached
//   DONE  | single cycle; load_done asserted, then back to IDLE
module pe_weight_spad_loader #(
  parameter  int ADDR_W     = 8,
  parameter  int DATA_W     = 13,
  parameter  int ADDR_DEPTH = 16,
  parameter  int DATA_DEPTH = 192,
  localparam int AIDX_W     = $clog2(ADDR_DEPTH),
  localparam int DIDX_W     = $clog2(DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [AIDX_W:0]   addr_len,
  input  logic [DIDX_W:0]   data_len,
  input  logic              addr_in_valid,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              aspad_we,
  output logic [AIDX_W-1:0] aspad_waddr,
  output logic [ADDR_W-1:0] aspad_wdata,
  output logic              dspad_we,
  output logic [DIDX_W-1:0] dspad_waddr,
  output logic [DATA_W-1:0] dspad_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              drop_err,
  output logic              format_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AIDX_W:0] ADDR_MAX = (AIDX_W+1)'(ADDR_DEPTH);
  localparam logic [DIDX_W:0] DATA_MAX = (DIDX_W+1)'(DATA_DEPTH);

  state_t state, state_nxt;

  logic [AIDX_W:0] a_cnt, a_cnt_nxt, addr_len_q, addr_len_c;
  logic [DIDX_W:0] d_cnt, d_cnt_nxt, data_len_q, data_len_c;
  logic            a_acc, d_acc, start_acc, a_clamp, d_clamp;
  logic            drop_set, fmt_set;

  // Beat acceptance, length clamping and error detection.
  always_comb begin
    start_acc  = (state == IDLE) && load_start;
    a_clamp    = addr_len > ADDR_MAX;
    d_clamp    = data_len > DATA_MAX;
    addr_len_c = a_clamp ? ADDR_MAX : addr_len;
    data_len_c = d_clamp ? DATA_MAX : data_len;
    a_acc      = (state == LOAD) && addr_in_valid && (a_cnt < addr_len_q);
    d_acc      = (state == LOAD) && data_in_valid && (d_cnt < data_len_q);
    a_cnt_nxt  = a_cnt + (AIDX_W+1)'(a_acc);
    d_cnt_nxt  = d_cnt + (DIDX_W+1)'(d_acc);
    drop_set   = (addr_in_valid && !a_acc) || (data_in_valid && !d_acc) ||
                 (start_acc && (a_clamp || d_clamp));
    // The final column pointer of a CSC filter must equal the number of data beats.
    fmt_set    = a_acc && (a_cnt_nxt == addr_len_q) &&
                 (32'(addr_in) != 32'(data_len_q));
  end

  // Next-state logic; completion counts include beats accepted this cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load_start) state_nxt = LOAD;
      LOAD: if ((a_cnt_nxt == addr_len_q) && (d_cnt_nxt == data_len_q)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counters, latched lengths and registered SPad write ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt       <= '0;
      d_cnt       <= '0;
      addr_len_q  <= '0;
      data_len_q  <= '0;
      aspad_we    <= 1'b0;
      aspad_waddr <= '0;
      aspad_wdata <= '0;
      dspad_we    <= 1'b0;
      dspad_waddr <= '0;
      dspad_wdata <= '0;
    end else begin
      aspad_we <= a_acc;
      dspad_we <= d_acc;
      if (a_acc) begin
        aspad_waddr <= a_cnt[AIDX_W-1:0];
        aspad_wdata <= addr_in;
      end
      if (d_acc) begin
        dspad_waddr <= d_cnt[DIDX_W-1:0];
        dspad_wdata <= data_in;
      end
      if (start_acc) begin
        a_cnt      <= '0;
        d_cnt      <= '0;
        addr_len_q <= addr_len_c;
        data_len_q <= data_len_c;
      end else begin
        a_cnt <= a_cnt_nxt;
        d_cnt <= d_cnt_nxt;
      end
    end
  end

  // Status outputs and sticky error flags; a new error wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      load_done  <= 1'b0;
      drop_err   <= 1'b0;
      format_err <= 1'b0;
    end else begin
      busy       <= (state_nxt == LOAD);
      load_done  <= (state_nxt == DONE);
      drop_err   <= drop_set | (drop_err & ~err_clr);
      format_err <= fmt_set  | (format_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_pe_weight_spad_loader.sv
// Bench for pe_weight_spad_loader: table of filter loads plus hand-written
// sequences for cycle timing, edge starts and reset during a load.
module tb_pe_weight_spad_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [4:0]  addr_len;
  logic [8:0]  data_len;
  logic        addr_in_valid;
  logic [7:0]  addr_in;
  logic        data_in_valid;
  logic [12:0] data_in;
  logic        aspad_we;
  logic [3:0]  aspad_waddr;
  logic [7:0]  aspad_wdata;
  logic        dspad_we;
  logic [7:0]  dspad_waddr;
  logic [12:0] dspad_wdata;
  logic        busy, load_done, drop_err, format_err, err_clr;

  always #5 clk = ~clk;

  pe_weight_spad_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .addr_len(addr_len), .data_len(data_len),
    .addr_in_valid(addr_in_valid), .addr_in(addr_in), .data_in_valid(data_in_valid), .data_in(data_in),
    .aspad_we(aspad_we), .aspad_waddr(aspad_waddr), .aspad_wdata(aspad_wdata),
    .dspad_we(dspad_we), .dspad_waddr(dspad_waddr), .dspad_wdata(dspad_wdata),
    .busy(busy), .load_done(load_done), .drop_err(drop_err), .format_err(format_err),
    .err_clr(err_clr)
  );

  typedef struct {int idx; int val;} exp_t;
  typedef struct {int alen; int dlen; int na; int nd; int last; bit gap; bit exp_drop; bit exp_fmt;} vec_t;

  exp_t aq[$];
  exp_t dq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write strobe must match the oldest expected beat.
  exp_t ea, ed;
  always @(negedge clk) begin
    if (load_done) done_cnt++;
    if (aspad_we) begin
      if (aq.size() == 0) check("aspad unexpected we", 1, 0);
      else begin
        ea = aq.pop_front();
        check("aspad_waddr", int'(aspad_waddr), ea.idx);
        check("aspad_wdata", int'(aspad_wdata), ea.val);
      end
    end
    if (dspad_we) begin
      if (dq.size() == 0) check("dspad unexpected we", 1, 0);
      else begin
        ed = dq.pop_front();
        check("dspad_waddr", int'(dspad_waddr), ed.idx);
        check("dspad_wdata", int'(dspad_wdata), ed.val);
      end
    end
  end

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic run_load(input vec_t v, input string tag);
    int ac, dc, ia, id, done0, c, w;
    ac = (v.alen > 16) ? 16 : v.alen;
    dc = (v.dlen > 192) ? 192 : v.dlen;
    clear_errs();
    done0 = done_cnt;
    load_start = 1'b1;
    addr_len   = 5'(v.alen);
    data_len   = 9'(v.dlen);
    tick();
    load_start = 1'b0;
    ia = 0; id = 0; c = 0;
    while ((ia < v.na || id < v.nd) && c < 400) begin
      addr_in_valid = 1'b0;
      data_in_valid = 1'b0;
      if (ia < v.na && (!v.gap || (c % 3) != 1)) begin
        addr_in_valid = 1'b1;
        addr_in = (ia == ac - 1) ? 8'(v.last) : 8'(ia + 2);
        if (ia < ac) aq.push_back('{ia, int'(addr_in)});
        ia++;
      end
      if (id < v.nd && (!v.gap || (c % 2) == 0)) begin
        data_in_valid = 1'b1;
        data_in = 13'((id * 37 + 5) % 8192);
        if (id < dc) dq.push_back('{id, int'(data_in)});
        id++;
      end
      tick();
      c++;
    end
    addr_in_valid = 1'b0;
    data_in_valid = 1'b0;
    w = 0;
    while (done_cnt == done0 && w < 30) begin
      tick();
      w++;
    end
    tick();
    tick();
    check({tag, " load_done count"}, done_cnt - done0, 1);
    check({tag, " aspad pending"}, aq.size(), 0);
    check({tag, " dspad pending"}, dq.size(), 0);
    check({tag, " drop_err"}, int'(drop_err), int'(v.exp_drop));
    check({tag, " format_err"}, int'(format_err), int'(v.exp_fmt));
    clear_errs();
    check({tag, " drop_err after clr"}, int'(drop_err), 0);
    check({tag, " format_err after clr"}, int'(format_err), 0);
    aq.delete();
    dq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done0;
    int exp_we[5], exp_busy[5], exp_done[5];

    vecs[0] = '{4, 6, 4, 6, 6, 1'b1, 1'b0, 1'b0};  // basic with gaps
    vecs[1] = '{1, 2, 1, 3, 2, 1'b0, 1'b1, 1'b0};  // data overrun
    vecs[2] = '{2, 5, 2, 5, 4, 1'b0, 1'b0, 1'b1};  // bad final pointer
    vecs[3] = '{20, 2, 16, 2, 2, 1'b0, 1'b1, 1'b0}; // addr_len clamp
    vecs[4] = '{2, 2, 3, 2, 2, 1'b1, 1'b1, 1'b0};  // addr overrun
    vecs[5] = '{1, 1, 1, 1, 1, 1'b1, 1'b0, 1'b0};  // minimal

    rst = 1'b1; load_start = 1'b0; addr_len = '0; data_len = '0;
    addr_in_valid = 1'b0; addr_in = '0; data_in_valid = 1'b0; data_in = '0; err_clr = 1'b0;
    #12;
    check("reset busy", int'(busy), 0);
    check("reset load_done", int'(load_done), 0);
    check("reset aspad_we", int'(aspad_we), 0);
    check("reset dspad_we", int'(dspad_we), 0);
    check("reset drop_err", int'(drop_err), 0);
    check("reset format_err", int'(format_err), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous streams: per-cycle we / busy / load_done profile.
    exp_we   = '{0, 1, 1, 1, 0};
    exp_busy = '{1, 1, 1, 0, 0};
    exp_done = '{0, 0, 0, 1, 0};
    load_start = 1'b1; addr_len = 5'd3; data_len = 9'd3;
    tick();
    load_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      addr_in_valid = (c <= 3);
      data_in_valid = (c <= 3);
      if (c <= 3) begin
        addr_in = 8'(c);
        data_in = 13'(c * 100);
        aq.push_back('{c - 1, c});
        dq.push_back('{c - 1, c * 100});
      end
      @(negedge clk);
      check($sformatf("simul c%0d aspad_we", c), int'(aspad_we), exp_we[c-1]);
      check($sformatf("simul c%0d dspad_we", c), int'(dspad_we), exp_we[c-1]);
      check($sformatf("simul c%0d busy", c), int'(busy), exp_busy[c-1]);
      check($sformatf("simul c%0d load_done", c), int'(load_done), exp_done[c-1]);
      tick();
    end
    addr_in_valid = 1'b0; data_in_valid = 1'b0;
    check("simul format_err", int'(format_err), 0);
    check("simul drop_err", int'(drop_err), 0);

    // Beats while idle are dropped and never written.
    clear_errs();
    addr_in_valid = 1'b1; addr_in = 8'd9; data_in_valid = 1'b1; data_in = 13'd77;
    tick();
    addr_in_valid = 1'b0; data_in_valid = 1'b0;
    @(negedge clk);
    check("idle beat aspad_we", int'(aspad_we), 0);
    check("idle beat dspad_we", int'(dspad_we), 0);
    check("idle beat drop_err", int'(drop_err), 1);
    clear_errs();

    // Zero-length load: load_done two cycles after the start pulse.
    load_start = 1'b1; addr_len = 5'd0; data_len = 9'd0;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    check("zero len c1 busy", int'(busy), 1);
    check("zero len c1 load_done", int'(load_done), 0);
    tick();
    @(negedge clk);
    check("zero len c2 load_done", int'(load_done), 1);
    check("zero len c2 aspad_we", int'(aspad_we), 0);
    tick();
    tick();

    // load_start during LOAD must not relatch lengths.
    clear_errs();
    done0 = done_cnt;
    load_start = 1'b1; addr_len = 5'd2; data_len = 9'd1;
    tick();
    addr_len = 5'd5; data_len = 9'd9;
    addr_in_valid = 1'b1; addr_in = 8'd7; aq.push_back('{0, 7});
    data_in_valid = 1'b1; data_in = 13'd100; dq.push_back('{0, 100});
    tick();
    load_start = 1'b0; data_in_valid = 1'b0;
    addr_in = 8'd1; aq.push_back('{1, 1});
    tick();
    addr_in_valid = 1'b0;
    tick(); tick();
    check("restart ignored load_done", done_cnt - done0, 1);
    check("restart ignored drop_err", int'(drop_err), 0);
    check("restart ignored format_err", int'(format_err), 0);
    check("restart ignored aspad pending", aq.size(), 0);

    // Reset after two of four address beats.
    clear_errs();
    done0 = done_cnt;
    load_start = 1'b1; addr_len = 5'd4; data_len = 9'd4;
    tick();
    load_start = 1'b0;
    addr_in_valid = 1'b1; addr_in = 8'd2; aq.push_back('{0, 2});
    tick();
    addr_in = 8'd3; aq.push_back('{1, 3});
    tick();
    addr_in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid reset busy", int'(busy), 0);
    check("mid reset aspad_we", int'(aspad_we), 0);
    check("mid reset load_done", int'(load_done), 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("mid reset no load_done", done_cnt - done0, 0);
    check("mid reset aspad pending", aq.size(), 0);
    aq.delete(); dq.delete();
    run_load(vecs[5], "post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
